// File: rtl/mem_arb_pkg.sv
// Shared response codes and FSM state type for the memory-port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] MEM_OKAY  = 2'b00;
    localparam logic [1:0] MEM_ERROR = 2'b01;
    localparam logic [1:0] MEM_WAIT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } memArbState_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request after last_grant_i wins,
// wrapping around to index 0.
module rr_pick #(
    parameter  int NumReq = 4,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_grant_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   grant_idx_o
);

    logic found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        // Requests above the last grant outrank the wrapped-around lower ones.
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_i[i] && (i > int'(last_grant_i))) begin
                found       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = IdxW'(i);
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_i[i]) begin
                found       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between NumReq requesters;
// latches the winner's transfer, waits for a final response, returns it to the winner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NumReq-1:0]             reqValid,
    output logic [NumReq-1:0]             reqReady,
    input  logic [NumReq*AddrWidth-1:0]   reqAddr,
    input  logic [NumReq*DataWidth-1:0]   reqWData,
    input  logic [NumReq-1:0]             reqWrite,
    output logic [NumReq-1:0]             rspValid,
    output logic [1:0]                    rspResp,
    output logic [DataWidth-1:0]          rspData,
    output logic                          memReq,
    output logic [AddrWidth-1:0]          memAddr,
    output logic [DataWidth-1:0]          memWData,
    output logic                          memWrite,
    input  logic [1:0]                    memResp,
    input  logic [DataWidth-1:0]          memRData
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] WaitLimit = CntW'(TimeoutCycles);

    memArbState_t          state_q, state_d;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    logic [NumReq-1:0]     grant_q, grant_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [1:0]            resp_q, resp_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic [NumReq-1:0]     rsp_valid_q, rsp_valid_d;

    logic [NumReq-1:0]     pick_grant;
    logic [IdxW-1:0]       pick_idx;
    logic [AddrWidth-1:0]  sel_addr;
    logic [DataWidth-1:0]  sel_wdata;
    logic                  sel_write;

    rr_pick #(.NumReq(NumReq)) u_pick (
        .req_i        (reqValid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .grant_idx_o  (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (pick_grant[i]) begin
                sel_addr  = reqAddr[i*AddrWidth +: AddrWidth];
                sel_wdata = reqWData[i*DataWidth +: DataWidth];
                sel_write = reqWrite[i];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value up front so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        wait_cnt_d   = wait_cnt_q;
        resp_d       = resp_q;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        rsp_valid_d  = '0;
        reqReady     = '0;

        case (state_q)
            IDLE: begin
                if (|reqValid) begin
                    reqReady     = pick_grant;
                    grant_d      = pick_grant;
                    last_grant_d = pick_idx;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    write_d      = sel_write;
                    wait_cnt_d   = '0;
                    mem_req_d    = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (memResp == MEM_WAIT && wait_cnt_q != WaitLimit) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    // Timeout and the reserved code both collapse to ERROR.
                    if (memResp == MEM_WAIT) begin
                        resp_d  = MEM_ERROR;
                        rdata_d = '0;
                    end else begin
                        resp_d  = (memResp == MEM_OKAY) ? MEM_OKAY : MEM_ERROR;
                        rdata_d = write_q ? '0 : memRData;
                    end
                    mem_req_d   = 1'b0;
                    rsp_valid_d = grant_q;
                    state_d     = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IdxW'(NumReq - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            wait_cnt_q   <= '0;
            resp_q       <= '0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_q       <= resp_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rspValid = rsp_valid_q;
    assign rspResp  = resp_q;
    assign rspData  = rdata_q;
    assign memReq   = mem_req_q;
    assign memAddr  = addr_q;
    assign memWData = wdata_q;
    assign memWrite = write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transfers, fairness, and reset-in-BUSY,
// with a response scoreboard fed at acceptance and drained on rspValid.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     reqValid;
    logic [NR-1:0]     reqReady;
    logic [NR*AW-1:0]  reqAddr;
    logic [NR*DW-1:0]  reqWData;
    logic [NR-1:0]     reqWrite;
    logic [NR-1:0]     rspValid;
    logic [1:0]        rspResp;
    logic [DW-1:0]     rspData;
    logic              memReq;
    logic [AW-1:0]     memAddr;
    logic [DW-1:0]     memWData;
    logic              memWrite;
    logic [1:0]        memResp;
    logic [DW-1:0]     memRData;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NR-1:0] mask;
        int            id;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [1:0]    mresp;
        logic [DW-1:0] rdata;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_data;
    } xfer_t;

    typedef struct {
        int            id;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t  sb[$];
    xfer_t vecs[8];

    mem_arbiter #(
        .NumReq(NR), .DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqAddr(reqAddr), .reqWData(reqWData), .reqWrite(reqWrite),
        .rspValid(rspValid), .rspResp(rspResp), .rspData(rspData),
        .memReq(memReq), .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite),
        .memResp(memResp), .memRData(memRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Scoreboard drain: every rspValid pulse must match the oldest accepted transfer.
    always @(negedge clk) begin
        if (rspValid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rspValid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_onehot", 32'(rspValid), 32'(onehot(e.id)));
                check("rsp_resp", 32'(rspResp), 32'(e.resp));
                check("rsp_data", rspData, e.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_reqReady"}, 32'(reqReady), 32'd0);
        check({tag, "_rspValid"}, 32'(rspValid), 32'd0);
        check({tag, "_rspResp"}, 32'(rspResp), 32'd0);
        check({tag, "_rspData"}, rspData, 32'd0);
        check({tag, "_memReq"}, 32'(memReq), 32'd0);
        check({tag, "_memAddr"}, memAddr, 32'd0);
        check({tag, "_memWData"}, memWData, 32'd0);
        check({tag, "_memWrite"}, 32'(memWrite), 32'd0);
    endtask

    // One transfer from the IDLE cycle through its RESP cycle; returns at the RESP negedge.
    task automatic run_xfer(input xfer_t v);
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            reqAddr[i*AW +: AW]  = ~v.addr;
            reqWData[i*DW +: DW] = ~v.wdata;
            reqWrite[i]          = ~v.write;
        end
        reqAddr[v.id*AW +: AW]  = v.addr;
        reqWData[v.id*DW +: DW] = v.wdata;
        reqWrite[v.id]          = v.write;
        reqValid = v.mask;
        #1;
        check("x_ready", 32'(reqReady), 32'(onehot(v.id)));
        sb.push_back('{v.id, v.exp_resp, v.exp_data});
        @(negedge clk);
        reqValid = '0;
        memRData = v.rdata;
        check("x_memReq", 32'(memReq), 32'd1);
        check("x_memAddr", memAddr, v.addr);
        check("x_memWData", memWData, v.wdata);
        check("x_memWrite", 32'(memWrite), 32'(v.write));
        for (int w = 0; w < v.waits; w++) begin
            memResp = MEM_WAIT;
            @(negedge clk);
            check("w_memReq", 32'(memReq), 32'd1);
            check("w_memAddr", memAddr, v.addr);
            check("w_rspValid", 32'(rspValid), 32'd0);
        end
        memResp = v.mresp;
        @(negedge clk);
        check("x_rspValid", 32'(rspValid), 32'(onehot(v.id)));
        check("x_memReq_low", 32'(memReq), 32'd0);
        memResp = MEM_OKAY;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // mask, winner, write, addr, wdata, waits, mem code, rdata, exp resp, exp data
        vecs[0] = '{4'b0010, 1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0,  MEM_OKAY,  32'hAAAA_5555, MEM_OKAY,  32'h0};
        vecs[1] = '{4'b0100, 2, 1'b0, 32'h0000_0040, 32'h1111_1111, 3,  MEM_OKAY,  32'h1234_5678, MEM_OKAY,  32'h1234_5678};
        vecs[2] = '{4'b1011, 3, 1'b0, 32'h0000_0300, 32'h2222_2222, 0,  MEM_ERROR, 32'hCAFE_F00D, MEM_ERROR, 32'hCAFE_F00D};
        vecs[3] = '{4'b1011, 0, 1'b0, 32'h0000_0304, 32'h3333_3333, 0,  2'b11,     32'h0BAD_F00D, MEM_ERROR, 32'h0BAD_F00D};
        vecs[4] = '{4'b1011, 1, 1'b1, 32'h0000_0308, 32'h4444_4444, 2,  2'b11,     32'h5555_5555, MEM_ERROR, 32'h0};
        vecs[5] = '{4'b1001, 3, 1'b0, 32'h0000_0400, 32'h6666_6666, TO, MEM_WAIT,  32'h0,         MEM_ERROR, 32'h0};
        vecs[6] = '{4'b0110, 1, 1'b0, 32'h0000_0404, 32'h7777_7777, TO, MEM_OKAY,  32'h600D_600D, MEM_OKAY,  32'h600D_600D};
        vecs[7] = '{4'b0001, 0, 1'b0, 32'h0000_0408, 32'h8888_8888, 1,  MEM_OKAY,  32'hFFFF_FFFF, MEM_OKAY,  32'hFFFF_FFFF};

        reset    = 1'b1;
        reqValid = '0;
        reqAddr  = '0;
        reqWData = '0;
        reqWrite = '0;
        memResp  = MEM_OKAY;
        memRData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_xfer(vecs[k]);
        end

        // Reset while the controller is stalling: transfer abandoned, no response.
        @(negedge clk);
        reqAddr[2*AW +: AW] = 32'h0000_0500;
        reqWData[2*DW +: DW] = 32'h9999_9999;
        reqWrite[2] = 1'b1;
        reqValid = 4'b0100;
        #1;
        check("rb_ready", 32'(reqReady), 32'(onehot(2)));
        @(negedge clk);
        reqValid = '0;
        memResp  = MEM_WAIT;
        check("rb_memAddr", memAddr, 32'h0000_0500);
        @(negedge clk);
        check("rb_memReq", 32'(memReq), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset   = 1'b0;
        memResp = MEM_OKAY;

        // Fairness: everyone requests continuously; grants rotate from requester 0.
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            reqAddr[i*AW +: AW]  = 32'h0000_1000 + 32'(i * 4);
            reqWData[i*DW +: DW] = 32'(i);
            reqWrite[i]          = 1'b0;
        end
        reqValid = '1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NR;
            #1;
            check("fair_ready", 32'(reqReady), 32'(onehot(g)));
            sb.push_back('{g, MEM_OKAY, 32'hF000_0000 + 32'(k)});
            @(negedge clk);
            memRData = 32'hF000_0000 + 32'(k);
            check("fair_memAddr", memAddr, 32'h0000_1000 + 32'(g * 4));
            check("fair_busy_ready", 32'(reqReady), 32'd0);
            @(negedge clk);
            check("fair_rspValid", 32'(rspValid), 32'(onehot(g)));
            check("fair_resp_ready", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
        reqValid = '0;
        repeat (2) @(negedge clk);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
